seven_seg_seconds: RTL and testbench
====================================

SEVEN_SEG_SECONDS -- requirements
Module: seven_seg_seconds

Interface
REQ-001 The module SHALL have parameter DEFAULT_COMPARE, default 24'd16_000_000, the tick period in clk cycles loaded at reset.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The module SHALL have port compare_in, input, 24 bits, the new tick period value.
REQ-005 The module SHALL have port update_compare, input, 1 bit, load strobe for compare_in, sampled on clk.
REQ-006 The module SHALL have port led_out, output, 7 bits, active-high segments {g,f,e,d,c,b,a} = led_out[6:0].

Function
REQ-007 The module SHALL hold a 24-bit compare register, a 24-bit cycle counter and a 4-bit digit register (range 0-9).
REQ-008 Each clk cycle without reset or update_compare, the cycle counter SHALL increment by 1.
REQ-009 When the cycle counter equals compare-1, the next edge SHALL clear it to 0 and advance the digit, giving one digit step every compare cycles.
REQ-010 The digit SHALL advance 0,1,...,9 and wrap from 9 to 0 on the following tick.
REQ-011 A compare value of 0 or 1 SHALL produce a digit step on every clk cycle; the counter never exceeds 0 in that case.
REQ-012 With update_compare high, the edge SHALL load compare <= compare_in and clear the cycle counter to 0; the digit is unchanged and no tick occurs on that edge.
REQ-013 If update_compare stays high for several cycles, the module SHALL reload compare and hold the counter at 0 on each of those cycles.
REQ-014 led_out SHALL be a combinational decode of the digit register, with no extra latency. Required codes:
- 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
- 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
REQ-015 The decoder SHALL drive an unreachable digit value (10-15) to 0x00.
REQ-016 The counter SHALL compare by equality against compare-1 using 24-bit unsigned arithmetic. No counter state survives a period change, because update_compare clears the counter.

Reset
REQ-017 When reset is high at a clk edge, the module SHALL set compare <= DEFAULT_COMPARE, counter <= 0 and digit <= 0; led_out then reads 0x3F.
REQ-018 Reset SHALL take priority over update_compare and over a tick occurring on the same edge.
REQ-019 Reset asserted mid-count SHALL discard the partial period; the first tick after reset release occurs compare cycles later.
REQ-020 The module SHALL have no asynchronous reset path; outputs before the first reset edge are undefined.

Verification
REQ-021 Reset, then hold idle for 20 cycles with the default period -> led_out stays 0x3F.
REQ-022 Reset, then pulse update_compare with compare_in=4, then run 4 cycles -> led_out goes 0x3F to 0x06 exactly on the 4th edge after the update edge.
REQ-023 With compare=4, run 40 cycles after the update -> led_out walks 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07, 0x7F, 0x6F, then 0x3F (wrap) at cycle 40.
REQ-024 With compare=4, pulse update_compare with compare_in=2 two cycles into a period -> the digit is held and the next step occurs 2 cycles after the update edge.
REQ-025 With compare_in=1 loaded -> the digit advances every cycle and wraps 9->0 after 10 cycles.
REQ-026 Assert reset and update_compare on the same edge while the digit is 5 -> led_out becomes 0x3F and compare equals DEFAULT_COMPARE, checked by no tick within 100 cycles.

Source files
------------

// File: rtl/seven_seg_seconds.sv
// Decimal seconds counter on a single seven-segment digit. The tick period
// in clk cycles can be reloaded at run time.
module seven_seg_seconds #(
  parameter logic [23:0] DEFAULT_COMPARE = 24'd16_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] compare_in,
  input  logic        update_compare,
  output logic [6:0]  led_out
);

  logic [23:0] compare_q, compare_d;
  logic [23:0] count_q, count_d;
  logic [3:0]  digit_q, digit_d;
  logic        tick;

  // Periods of 0 and 1 both tick every cycle; compare-1 would wrap for 0.
  assign tick = (compare_q < 24'd2) || (count_q == (compare_q - 24'd1));

  always_comb begin
    compare_d = compare_q;
    count_d   = count_q + 24'd1;
    digit_d   = digit_q;
    if (update_compare) begin
      compare_d = compare_in;
      count_d   = 24'd0;
    end else if (tick) begin
      count_d = 24'd0;
      digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      compare_q <= DEFAULT_COMPARE;
      count_q   <= 24'd0;
      digit_q   <= 4'd0;
    end else begin
      compare_q <= compare_d;
      count_q   <= count_d;
      digit_q   <= digit_d;
    end
  end

  // Segment order {g,f,e,d,c,b,a}, active high.
  always_comb begin
    led_out = 7'h00;
    case (digit_q)
      4'd0:    led_out = 7'h3F;
      4'd1:    led_out = 7'h06;
      4'd2:    led_out = 7'h5B;
      4'd3:    led_out = 7'h4F;
      4'd4:    led_out = 7'h66;
      4'd5:    led_out = 7'h6D;
      4'd6:    led_out = 7'h7D;
      4'd7:    led_out = 7'h07;
      4'd8:    led_out = 7'h7F;
      4'd9:    led_out = 7'h6F;
      default: led_out = 7'h00;
    endcase
  end

endmodule

// File: tb/tb_seven_seg_seconds.sv
// Directed bench for seven_seg_seconds: inputs change after the falling edge,
// led_out is checked at the following falling edge.
module tb_seven_seg_seconds;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] compare_in;
  logic        update_compare;
  logic [6:0]  led_out;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_d = 0;
  logic [6:0] seg_tab [10];

  seven_seg_seconds dut (
    .clk            (clk),
    .reset          (reset),
    .compare_in     (compare_in),
    .update_compare (update_compare),
    .led_out        (led_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [6:0] expected);
    total_cnt++;
    assert (led_out === expected) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: led_out=%h expected %h", tag, led_out, expected);
    end
    $display("check %0d %s: led_out=%h expected %h", total_cnt, tag, led_out, expected);
  endtask

  task automatic adv();
    exp_d = (exp_d + 1) % 10;
  endtask

  initial begin
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;

    reset = 1'b1; update_compare = 1'b0; compare_in = 24'd0;
    step(); step();
    reset = 1'b0;
    chk("reset", 7'h3F);

    // Default period: nothing happens in 20 cycles.
    for (int i = 0; i < 20; i++) begin
      step(); chk("idle_default", 7'h3F);
    end

    // Period 4: first step lands on the 4th edge after the load edge.
    update_compare = 1'b1; compare_in = 24'd4;
    step(); update_compare = 1'b0;
    chk("load4_edge", 7'h3F);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k % 4 == 0) adv();
      chk("walk4", seg_tab[exp_d]);
    end
    chk("walk4_wrap", 7'h3F);

    // Reload to 2 two cycles into a period: digit holds, step 2 cycles later.
    step(); chk("pre_reload", 7'h3F);
    step(); chk("pre_reload", 7'h3F);
    update_compare = 1'b1; compare_in = 24'd2;
    step(); update_compare = 1'b0;
    chk("reload2_edge", 7'h3F);
    step(); chk("reload2_c1", 7'h3F);
    step(); adv(); chk("reload2_c2", 7'h06);

    // Held update: counter pinned at 0, digit frozen.
    update_compare = 1'b1; compare_in = 24'd3;
    for (int i = 0; i < 5; i++) begin
      step(); chk("hold_update", 7'h06);
    end
    update_compare = 1'b0;
    step(); chk("p3_c1", 7'h06);
    step(); chk("p3_c2", 7'h06);
    step(); adv(); chk("p3_c3", 7'h5B);

    // Period 1: one step per cycle, crossing the 9->0 wrap.
    update_compare = 1'b1; compare_in = 24'd1;
    step(); update_compare = 1'b0;
    chk("load1_edge", 7'h5B);
    for (int i = 0; i < 10; i++) begin
      step(); adv(); chk("p1_step", seg_tab[exp_d]);
    end
    chk("p1_back_to_2", 7'h5B);

    // Period 0 behaves like period 1.
    update_compare = 1'b1; compare_in = 24'd0;
    step(); update_compare = 1'b0;
    chk("load0_edge", 7'h5B);
    for (int i = 0; i < 3; i++) begin
      step(); adv(); chk("p0_step", seg_tab[exp_d]);
    end
    chk("digit5", 7'h6D);

    // Reset beats update: compare must return to the long default.
    reset = 1'b1; update_compare = 1'b1; compare_in = 24'd3;
    step(); reset = 1'b0; update_compare = 1'b0;
    exp_d = 0;
    chk("rst_over_upd", 7'h3F);
    for (int i = 0; i < 100; i++) begin
      step(); chk("no_tick_default", 7'h3F);
    end

    // Reset mid-count discards the partial period.
    update_compare = 1'b1; compare_in = 24'd6;
    step(); update_compare = 1'b0;
    step(); step(); step();
    chk("mid_count", 7'h3F);
    reset = 1'b1;
    step(); reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); chk("after_mid_rst", 7'h3F);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
